// File: rtl/op_mode_pkg.sv
// Shared definitions for the operating-mode scheduler and its consumers
// (duty/phase mux, controller).
//   op_mode_state_t : scheduler FSM state encoding
//   MODE_NORMAL     : OP_MODE value selecting normal (gain) duty/phase
//   MODE_STM        : OP_MODE value selecting STM duty/phase
package op_mode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_WAIT_TIME     = 2'd1,
      ST_WAIT_BOUNDARY = 2'd2
   } op_mode_state_t;

   localparam logic MODE_NORMAL = 1'b0;
   localparam logic MODE_STM    = 1'b1;

endpackage

// File: rtl/op_mode_scheduler.sv
// Schedules the switch between normal and STM operation. A request is held
// until an optional absolute SYS_TIME target, then committed on the next
// ultrasound-period BOUNDARY (or forced by a watchdog) so a PWM period never
// mixes normal and STM duty/phase.
//
// Optional feature macro: OP_MODE_SCHEDULER_TIMED_EN
//   defined     : REQ_TIME honoured (WAIT_TIME state + comparator), LATE functional
//   not defined : REQ_TIME ignored, accept goes straight to WAIT_BOUNDARY, LATE = 0
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   SYS_TIME          synchronized system time (unsigned)
//   BOUNDARY          one-cycle pulse at the start of each ultrasound period
//   REQ_VALID/READY   request handshake
//   REQ_MODE          requested mode (0 normal, 1 STM)
//   REQ_TIME          absolute commit time, 0 = as soon as possible
//   OP_MODE           current mode select (registered)
//   STM_START         pulse on OP_MODE 0->1
//   DONE              pulse on every commit
//   LATE              pulse with DONE when nonzero REQ_TIME had already passed
//   TIMEOUT           pulse with DONE when commit was forced by the watchdog
//   BUSY              state != IDLE
module op_mode_scheduler #(
   parameter int unsigned TIME_WIDTH       = 64,
   parameter int unsigned BOUNDARY_TIMEOUT = 4096
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [TIME_WIDTH-1:0] SYS_TIME,
   input  logic                  BOUNDARY,
   input  logic                  REQ_VALID,
   input  logic                  REQ_MODE,
   input  logic [TIME_WIDTH-1:0] REQ_TIME,
   output logic                  REQ_READY,
   output logic                  OP_MODE,
   output logic                  STM_START,
   output logic                  DONE,
   output logic                  LATE,
   output logic                  TIMEOUT,
   output logic                  BUSY
);
   import op_mode_pkg::*;

   localparam int unsigned CW = $clog2(BOUNDARY_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(BOUNDARY_TIMEOUT - 1);

   op_mode_state_t state;
   logic [CW-1:0]  count;
   logic           pend_mode;
   logic           op_q;
   logic           done_q;
   logic           stm_q;
   logic           timeout_q;

`ifdef OP_MODE_SCHEDULER_TIMED_EN
   logic [TIME_WIDTH-1:0] pend_time;
   logic                  late_q;
   logic                  late_out_q;
   logic                  time_ok;
   logic                  req_late;

   assign time_ok  = (pend_time == '0) || (SYS_TIME >= pend_time);
   assign req_late = (REQ_TIME != '0) && (REQ_TIME <= SYS_TIME);
   assign REQ_READY = (state == ST_IDLE) || (state == ST_WAIT_TIME);
   assign LATE      = late_out_q;
`else
   logic unused_time;

   assign unused_time = ^{SYS_TIME, REQ_TIME};
   assign REQ_READY   = (state == ST_IDLE);
   assign LATE        = 1'b0;
`endif

   assign BUSY      = (state != ST_IDLE);
   assign OP_MODE   = op_q;
   assign STM_START = stm_q;
   assign DONE      = done_q;
   assign TIMEOUT   = timeout_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= ST_IDLE;
         count     <= '0;
         pend_mode <= MODE_NORMAL;
         op_q      <= MODE_NORMAL;
         done_q    <= 1'b0;
         stm_q     <= 1'b0;
         timeout_q <= 1'b0;
`ifdef OP_MODE_SCHEDULER_TIMED_EN
         pend_time  <= '0;
         late_q     <= 1'b0;
         late_out_q <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
         stm_q     <= 1'b0;
         timeout_q <= 1'b0;
`ifdef OP_MODE_SCHEDULER_TIMED_EN
         late_out_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (REQ_VALID) begin
                  pend_mode <= REQ_MODE;
`ifdef OP_MODE_SCHEDULER_TIMED_EN
                  pend_time <= REQ_TIME;
                  late_q    <= req_late;
                  state     <= ST_WAIT_TIME;
`else
                  count     <= '0;
                  state     <= ST_WAIT_BOUNDARY;
`endif
               end
            end
`ifdef OP_MODE_SCHEDULER_TIMED_EN
            ST_WAIT_TIME: begin
               // A new request takes priority over the time condition and
               // silently replaces the pending one.
               if (REQ_VALID) begin
                  pend_mode <= REQ_MODE;
                  pend_time <= REQ_TIME;
                  late_q    <= req_late;
               end else if (time_ok) begin
                  count <= '0;
                  state <= ST_WAIT_BOUNDARY;
               end
            end
`endif
            ST_WAIT_BOUNDARY: begin
               // BOUNDARY wins over the watchdog limit on the same edge.
               if (BOUNDARY || (count == LIMIT)) begin
                  op_q      <= pend_mode;
                  done_q    <= 1'b1;
                  stm_q     <= (pend_mode == MODE_STM) && (op_q == MODE_NORMAL);
                  timeout_q <= !BOUNDARY;
`ifdef OP_MODE_SCHEDULER_TIMED_EN
                  late_out_q <= late_q;
`endif
                  state     <= ST_IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_op_mode_scheduler.sv
module tb_op_mode_scheduler;

   localparam int unsigned TW = 64;
   localparam int unsigned TO = 16;
`ifdef OP_MODE_SCHEDULER_TIMED_EN
   localparam int unsigned TIMED = 1;
`else
   localparam int unsigned TIMED = 0;
`endif

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic [TW-1:0] SYS_TIME;
   logic          BOUNDARY;
   logic          REQ_VALID;
   logic          REQ_MODE;
   logic [TW-1:0] REQ_TIME;
   logic          REQ_READY;
   logic          OP_MODE;
   logic          STM_START;
   logic          DONE;
   logic          LATE;
   logic          TIMEOUT;
   logic          BUSY;

   always #5 CLK = ~CLK;

   op_mode_scheduler #(.TIME_WIDTH(TW), .BOUNDARY_TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .SYS_TIME(SYS_TIME), .BOUNDARY(BOUNDARY),
      .REQ_VALID(REQ_VALID), .REQ_MODE(REQ_MODE), .REQ_TIME(REQ_TIME),
      .REQ_READY(REQ_READY), .OP_MODE(OP_MODE), .STM_START(STM_START),
      .DONE(DONE), .LATE(LATE), .TIMEOUT(TIMEOUT), .BUSY(BUSY)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a pending request that becomes "eligible" on some edge;
   // from the following edge it commits on a boundary or TO edges later.
   bit            m_pend, m_mode, m_elig, m_late, m_op;
   logic [TW-1:0] m_time;
   int            m_elig_edge, edge_no;
   bit            e_done, e_stm, e_late, e_to;
   logic [TW-1:0] sys;

   function automatic bit m_ready();
      return !m_pend || (TIMED == 1 && !m_elig);
   endfunction

   function automatic void model_reset();
      m_pend = 0; m_mode = 0; m_elig = 0; m_late = 0; m_op = 0; m_time = '0;
      m_elig_edge = 0; edge_no = 0;
      e_done = 0; e_stm = 0; e_late = 0; e_to = 0;
   endfunction

   function automatic void model_step(bit v, bit md, logic [TW-1:0] rt, bit b, logic [TW-1:0] st);
      edge_no++;
      e_done = 0; e_stm = 0; e_late = 0; e_to = 0;
      if (m_pend && m_elig) begin
         if (b || (edge_no - m_elig_edge == TO)) begin
            e_done = 1;
            e_late = m_late;
            e_to   = !b;
            e_stm  = m_mode && !m_op;
            m_op   = m_mode;
            m_pend = 0;
            m_elig = 0;
         end
      end else if (v && m_ready()) begin
         m_pend = 1;
         m_mode = md;
         m_time = rt;
         m_late = (TIMED == 1) && (rt != 0) && (rt <= st);
         m_elig = (TIMED == 0);
         m_elig_edge = edge_no;
      end else if (m_pend && (m_time == 0 || st >= m_time)) begin
         m_elig = 1;
         m_elig_edge = edge_no;
      end
   endfunction

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic tick(input bit v, input bit md, input logic [TW-1:0] rt, input bit b);
      REQ_VALID = v; REQ_MODE = md; REQ_TIME = rt; BOUNDARY = b; SYS_TIME = sys;
      @(posedge CLK);
      model_step(v, md, rt, b, sys);
      #1;
      chk("op_mode", OP_MODE, m_op);
      chk("done", DONE, e_done);
      chk("stm_start", STM_START, e_stm);
      chk("late", LATE, e_late);
      chk("timeout", TIMEOUT, e_to);
      chk("busy", BUSY, m_pend);
      chk("req_ready", REQ_READY, m_ready());
      sys = sys + 1;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
   endtask

   typedef struct {
      bit v, md, b;
      bit op, done, stm, busy, ready;
   } vec_t;

   vec_t vt[$];

   initial begin
      int n;
      int dcount;
      logic [TW-1:0] rt;

      REQ_VALID = 0; REQ_MODE = 0; REQ_TIME = '0; BOUNDARY = 0; sys = 100; SYS_TIME = sys;
      RESET_N = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_op_mode", OP_MODE, 0);
      chk("rst_ready", REQ_READY, 1);
      chk("rst_done", DONE, 0);
      chk("rst_stm", STM_START, 0);
      chk("rst_late", LATE, 0);
      chk("rst_timeout", TIMEOUT, 0);
      chk("rst_busy", BUSY, 0);
      RESET_N = 1'b1;

      //          v  md b   op dn st bs rd
`ifdef OP_MODE_SCHEDULER_TIMED_EN
      vt.push_back('{1, 1, 0, 0, 0, 0, 1, 1});
      vt.push_back('{0, 0, 1, 0, 0, 0, 1, 0});  // boundary on eligibility edge ignored
      vt.push_back('{0, 0, 1, 1, 1, 1, 0, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 1});
      vt.push_back('{1, 0, 0, 1, 0, 0, 1, 1});
      vt.push_back('{1, 1, 0, 1, 0, 0, 1, 1});  // replaces pending mode 0
      vt.push_back('{0, 0, 0, 1, 0, 0, 1, 0});
      vt.push_back('{0, 0, 1, 1, 1, 0, 0, 1});  // same mode: DONE, no STM_START
      vt.push_back('{1, 0, 0, 1, 0, 0, 1, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 1, 0});
      vt.push_back('{0, 0, 1, 0, 1, 0, 0, 1});  // 1->0 without STM_START
`else
      vt.push_back('{1, 1, 0, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 1, 1, 1, 1, 0, 1});
      vt.push_back('{0, 0, 0, 1, 0, 0, 0, 1});
      vt.push_back('{1, 1, 1, 1, 0, 0, 1, 0});  // boundary on accept edge ignored
      vt.push_back('{0, 0, 0, 1, 0, 0, 1, 0});
      vt.push_back('{0, 0, 1, 1, 1, 0, 0, 1});  // same mode: DONE, no STM_START
      vt.push_back('{1, 0, 0, 1, 0, 0, 1, 0});
      vt.push_back('{0, 0, 1, 0, 1, 0, 0, 1});  // 1->0 without STM_START
      vt.push_back('{1, 1, 0, 0, 0, 0, 1, 0});
      vt.push_back('{1, 0, 1, 1, 1, 1, 0, 1});  // request while busy is not taken
`endif
      foreach (vt[i]) begin
         tick(vt[i].v, vt[i].md, '0, vt[i].b);
         chk("vec_op", OP_MODE, vt[i].op);
         chk("vec_done", DONE, vt[i].done);
         chk("vec_stm", STM_START, vt[i].stm);
         chk("vec_busy", BUSY, vt[i].busy);
         chk("vec_ready", REQ_READY, vt[i].ready);
      end

      // Watchdog: no BOUNDARY at all.
      tick(1, 1, '0, 0);
      n = 0;
      while (!DONE && n < 60) begin
         tick(0, 0, '0, 0);
         n++;
      end
      chk("timeout_latency", n, TO + TIMED);
      chk("timeout_flag", TIMEOUT, 1);

      // BOUNDARY coincident with the watchdog limit: normal commit.
      tick(1, 1, '0, 0);
      repeat (TO + TIMED - 1) tick(0, 0, '0, 0);
      tick(0, 0, '0, 1);
      chk("limit_boundary_done", DONE, 1);
      chk("limit_boundary_timeout", TIMEOUT, 0);

      // Reset asserted while waiting for the boundary.
      tick(1, 0, '0, 0);
      tick(0, 0, '0, 0);
      chk("pre_reset_busy", BUSY, 1);
      chk("pre_reset_op", OP_MODE, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("async_reset_op", OP_MODE, 0);
      chk("async_reset_busy", BUSY, 0);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      dcount = 0;
      repeat (25) begin
         tick(0, 0, '0, 0);
         dcount += int'(DONE);
      end
      chk("no_done_after_reset", dcount, 0);

`ifdef OP_MODE_SCHEDULER_TIMED_EN
      // Future target: nothing before 5000, LATE = 0.
      sys = 1000;
      tick(1, 1, 5000, 0);
      n = 0;
      dcount = 0;
      while (!DONE && n < 200) begin
         if (n == 20) sys = 4990;
         tick(0, 0, '0, (n % 5) == 4);
         if (DONE) chk("future_commit_time", (SYS_TIME >= 5000), 1);
         n++;
      end
      chk("future_done", DONE, 1);
      chk("future_late", LATE, 0);

      // Past target: LATE with DONE.
      sys = 500;
      tick(1, 1, 10, 0);
      n = 0;
      while (!DONE && n < 60) begin
         tick(0, 0, '0, (n % 3) == 2);
         n++;
      end
      chk("past_done", DONE, 1);
      chk("past_late", LATE, 1);

      // Replacement: 8000 superseded by 9000, single DONE.
      do_reset();
      sys = 7000;
      tick(1, 1, 8000, 0);
      repeat (3) tick(0, 0, '0, 0);
      tick(1, 1, 9000, 0);
      sys = 8000;
      dcount = 0;
      repeat (20) begin
         tick(0, 0, '0, (sys % 4) == 0);
         dcount += int'(DONE);
      end
      chk("replaced_no_early_done", dcount, 0);
      sys = 8995;
      repeat (30) begin
         tick(0, 0, '0, (sys % 4) == 0);
         dcount += int'(DONE);
      end
      chk("replaced_single_done", dcount, 1);
      chk("replaced_op", OP_MODE, 1);
`endif

      // Randomized traffic against the model.
      sys = 1000;
      repeat (3000) begin
         if ($urandom_range(0, 2) == 0) rt = '0;
         else rt = sys + $urandom_range(0, 60) - 20;
         tick($urandom_range(0, 7) == 0, 1'($urandom), rt, $urandom_range(0, 11) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
